// File: rtl/local_ram_reader.sv
// ============================================================================
// local_ram_reader
// ----------------------------------------------------------------------------
// Read-side sequencer for the byte-written local line RAM. On a start pulse it
// reads a run of consecutive words (wrapping modulo the RAM depth) beginning at
// base_addr and streams them to a downstream consumer over valid/ready. The
// RAM has a one-cycle registered read; a 2-entry output buffer absorbs that
// latency plus downstream back-pressure so no word is dropped or duplicated.
//
// Ports:
//   clk        single clock
//   rst        synchronous, active-high reset (aborts any run, no done pulse)
//   start      one-cycle request, only looked at while idle
//   base_addr  first word address, captured on an accepted start
//   length     number of words (0 .. 2**AddrWidth), captured on accepted start
//   rdaddr     registered address to the RAM read port
//   rd_data    RAM read data, valid the cycle after a read is issued
//   out_data   head of the output buffer
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts; a transfer is out_valid & out_ready
//   busy       high from the accepted start until the run completes
//   done       one-cycle pulse when a run completes
// ============================================================================
module local_ram_reader #(
    parameter int ByteWidth = 12,
    parameter int AddrWidth = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AddrWidth-1:0]   base_addr,
    input  logic [AddrWidth:0]     length,
    output logic [AddrWidth-1:0]   rdaddr,
    input  logic [ByteWidth*8-1:0] rd_data,
    output logic [ByteWidth*8-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int DataWidth = ByteWidth * 8;
    localparam logic [AddrWidth-1:0] AddrOne = 1;
    localparam logic [AddrWidth:0]   CntOne  = 1;
    localparam logic [AddrWidth:0]   CntZero = '0;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t state;
    state_t next_state;

    // Run bookkeeping: captured length, words issued to the RAM and words
    // handed to the consumer. One bit wider than the address so that a full
    // 2**AddrWidth run can be counted.
    logic [AddrWidth:0] len_reg;
    logic [AddrWidth:0] issued_cnt;
    logic [AddrWidth:0] xfer_cnt;

    // A read was issued last cycle, so rd_data carries a wanted word now.
    logic inflight;

    // Two-entry output FIFO.
    logic [DataWidth-1:0] buf_mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           buf_count;

    logic       pop;
    logic       push;
    logic       issue;
    logic       accept;
    logic       accept_zero;
    logic       last_issue;
    logic       last_xfer;
    logic [2:0] occupancy;

    // ------------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Leaving DRAIN only needs the final transfer: every
    // word has already been issued and pushed by then, so that transfer
    // empties the buffer and nothing can still be in flight.
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = READ;
                end
            end
            READ: begin
                if (last_issue) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (last_xfer) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / control decode. The issue rule counts what will occupy the
    // buffer after this cycle (buffered + in flight - leaving now); keeping
    // that below two means a newly issued word always has a free slot when
    // it lands, so the FIFO needs no overflow handling.
    // ------------------------------------------------------------------------
    always_comb begin
        pop         = out_valid & out_ready;
        push        = inflight;
        occupancy   = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        accept      = (state == IDLE) && start && (length != CntZero);
        accept_zero = (state == IDLE) && start && (length == CntZero);
        issue       = (state == READ) && (issued_cnt != len_reg)
                      && (occupancy < 3'd2);
        last_issue  = issue && ((issued_cnt + CntOne) == len_reg);
        last_xfer   = pop && ((xfer_cnt + CntOne) == len_reg);
        busy        = (state != IDLE);
    end

    // ------------------------------------------------------------------------
    // Address, counters, in-flight flag and done pulse. rdaddr only moves on
    // an issue, so it holds its value otherwise and wraps naturally at the
    // top of the RAM. A zero-length start only produces the done pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rdaddr     <= '0;
            len_reg    <= '0;
            issued_cnt <= '0;
            xfer_cnt   <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= accept_zero || ((state == DRAIN) && last_xfer);
            inflight <= issue;
            if (accept) begin
                rdaddr     <= base_addr;
                len_reg    <= length;
                issued_cnt <= '0;
                xfer_cnt   <= '0;
            end else begin
                if (issue) begin
                    rdaddr     <= rdaddr + AddrOne;
                    issued_cnt <= issued_cnt + CntOne;
                end
                if (pop) begin
                    xfer_cnt <= xfer_cnt + CntOne;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO. The word arriving on rd_data is pushed whenever the
    // previous cycle issued a read; data from non-issued cycles is ignored.
    // Simultaneous push and pop leaves the count unchanged.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= rd_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_comb begin
        out_data  = buf_mem[rd_ptr];
        out_valid = (buf_count != 2'd0);
    end

endmodule

// File: tb/tb_local_ram_reader.sv
// ============================================================================
// tb_local_ram_reader
// ----------------------------------------------------------------------------
// Bench for local_ram_reader. A RAM model with a registered read feeds the
// DUT; a reference model keeps the queue of words each run must deliver and
// the expected busy/done behaviour, and a compare process checks the DUT on
// every falling edge. Directed scenarios add hand-computed expectations.
// ============================================================================
`timescale 1ns/1ps
module tb_local_ram_reader;

    localparam int ByteWidth = 12;
    localparam int AddrWidth = 6;
    localparam int DataWidth = ByteWidth * 8;
    localparam int Depth     = 1 << AddrWidth;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [AddrWidth-1:0] base_addr;
    logic [AddrWidth:0]   length;
    logic [AddrWidth-1:0] rdaddr;
    logic [DataWidth-1:0] rd_data;
    logic [DataWidth-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;

    logic [DataWidth-1:0] ram [Depth];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // RAM with a one-cycle registered read that samples rdaddr every cycle.
    always @(posedge clk) begin
        rd_data <= ram[rdaddr];
    end

    local_ram_reader #(
        .ByteWidth(ByteWidth),
        .AddrWidth(AddrWidth)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .rdaddr(rdaddr),
        .rd_data(rd_data),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    task automatic checkOutput(input string name, input logic [DataWidth-1:0] actual,
                               input logic [DataWidth-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model state and event logs.
    // ------------------------------------------------------------------------
    logic [DataWidth-1:0] exp_q [$];
    bit                   m_busy = 1'b0;
    bit                   m_done = 1'b0;
    bit                   n_busy;
    bit                   n_done;
    bit                   after_rst = 1'b0;
    bit                   chk_rdaddr = 1'b0;
    logic [AddrWidth-1:0] m_rdaddr;
    logic [AddrWidth-1:0] nxt_addr;
    int                   issued_obs = 0;
    int                   xfer_n = 0;
    int                   run_len = 0;
    bit                   prev_valid = 1'b0;
    bit                   prev_ready = 1'b0;
    bit                   prev_busy = 1'b0;
    logic [DataWidth-1:0] prev_data;
    logic [AddrWidth-1:0] prev_rdaddr;
    int                   cyc = 0;
    int                   start_cyc = 0;
    int                   xfer_cyc [$];
    logic [DataWidth-1:0] xfer_val [$];
    logic [AddrWidth-1:0] iss_addr [$];
    int                   done_log [$];

    // Compare process: checks the DUT against the model every cycle, then
    // advances the model to what the next cycle must show.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_busy     = 1'b0;
            m_done     = 1'b0;
            after_rst  = 1'b1;
            chk_rdaddr = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            n_busy = m_busy;
            n_done = 1'b0;
            checkOutput("busy", busy, m_busy);
            checkOutput("done", done, m_done);
            if (after_rst) begin
                checkOutput("reset_out_valid", out_valid, 0);
                checkOutput("reset_rdaddr", rdaddr, 0);
            end
            if (chk_rdaddr) begin
                checkOutput("rdaddr_after_start", rdaddr, m_rdaddr);
            end
            if (!m_busy) begin
                checkOutput("idle_out_valid", out_valid, 0);
            end
            if (prev_valid && !prev_ready) begin
                checkOutput("stall_valid_held", out_valid, 1);
                checkOutput("stall_data_held", out_data, prev_data);
            end
            if (m_busy && prev_busy && rdaddr != prev_rdaddr) begin
                issued_obs++;
                iss_addr.push_back(prev_rdaddr);
                nxt_addr = prev_rdaddr + 6'd1;
                checkOutput("rdaddr_step", rdaddr, nxt_addr);
            end
            if (m_busy) begin
                checkOutput("outstanding_le2", (issued_obs - xfer_n) <= 2, 1);
                checkOutput("no_over_issue", issued_obs <= run_len, 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL extra_word: got %0d, expected no transfer", out_data);
                end else begin
                    checkOutput("out_data", out_data, exp_q.pop_front());
                    xfer_n++;
                    xfer_cyc.push_back(cyc);
                    xfer_val.push_back(out_data);
                    if (exp_q.size() == 0) begin
                        n_done = 1'b1;
                        n_busy = 1'b0;
                        checkOutput("issued_total", issued_obs, run_len);
                    end
                end
            end
            chk_rdaddr = 1'b0;
            if (start && !m_busy) begin
                start_cyc  = cyc;
                issued_obs = 0;
                xfer_n     = 0;
                run_len    = int'(length);
                chk_rdaddr = 1'b1;
                if (length == 0) begin
                    n_done   = 1'b1;
                    m_rdaddr = rdaddr;
                end else begin
                    n_busy   = 1'b1;
                    m_rdaddr = base_addr;
                    for (int i = 0; i < int'(length); i++) begin
                        exp_q.push_back(ram[(int'(base_addr) + i) % Depth]);
                    end
                end
            end
            if (done) begin
                done_log.push_back(cyc);
            end
            prev_valid  = out_valid;
            prev_ready  = out_ready;
            prev_busy   = m_busy;
            prev_data   = out_data;
            prev_rdaddr = rdaddr;
            m_busy      = n_busy;
            m_done      = n_done;
            after_rst   = 1'b0;
        end
        cyc++;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers.
    // ------------------------------------------------------------------------
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AddrWidth-1:0] base, input logic [AddrWidth:0] len,
                                 input bit clearLogs);
        if (clearLogs) begin
            xfer_cyc.delete();
            xfer_val.delete();
            iss_addr.delete();
            done_log.delete();
        end
        start     = 1'b1;
        base_addr = base;
        length    = len;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            nextCycle();
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done", budget);
        end
        nextCycle();
    endtask

    task automatic scenarioShortRun();
        out_ready = 1'b1;
        applyStimulus(6'd4, 7'd3, 1'b1);
        waitDone(50);
        checkOutput("s1_xfer_count", xfer_val.size(), 3);
        checkOutput("s1_done_count", done_log.size(), 1);
        if (xfer_val.size() >= 3 && done_log.size() >= 1) begin
            checkOutput("s1_first_latency", xfer_cyc[0] - start_cyc, 3);
            checkOutput("s1_word0", xfer_val[0], 4);
            checkOutput("s1_word1", xfer_val[1], 5);
            checkOutput("s1_word2", xfer_val[2], 6);
            checkOutput("s1_back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);
            checkOutput("s1_done_cycle", done_log[0] - start_cyc, 6);
        end
        checkOutput("s1_busy_after", busy, 0);
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios.
    // ------------------------------------------------------------------------
    initial begin
        int k;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < Depth; i++) begin
            ram[i] = DataWidth'(i);
        end
        repeat (3) nextCycle();
        rst = 1'b0;
        nextCycle();
        checkOutput("init_busy", busy, 0);
        checkOutput("init_rdaddr", rdaddr, 0);
        checkOutput("init_out_data", out_data, 0);

        $display("[TB] scenario: base=4 length=3");
        scenarioShortRun();
        nextCycle();

        $display("[TB] scenario: wrap base=62 length=4");
        applyStimulus(6'd62, 7'd4, 1'b1);
        waitDone(50);
        checkOutput("s2_xfer_count", xfer_val.size(), 4);
        checkOutput("s2_issue_count", iss_addr.size(), 4);
        if (xfer_val.size() >= 4 && iss_addr.size() >= 4) begin
            checkOutput("s2_word0", xfer_val[0], 62);
            checkOutput("s2_word1", xfer_val[1], 63);
            checkOutput("s2_word2", xfer_val[2], 0);
            checkOutput("s2_word3", xfer_val[3], 1);
            checkOutput("s2_addr0", iss_addr[0], 62);
            checkOutput("s2_addr1", iss_addr[1], 63);
            checkOutput("s2_addr2", iss_addr[2], 0);
            checkOutput("s2_addr3", iss_addr[3], 1);
        end

        $display("[TB] scenario: full run base=10 length=64 with back-pressure");
        out_ready = 1'b1;
        applyStimulus(6'd10, 7'd64, 1'b1);
        k = 0;
        while (!done && k < 1000) begin
            out_ready = ((k % 4) == 0) || ((k % 4) == 3);
            nextCycle();
            k++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL s3_done_timeout: got no done after %0d cycles, expected done", k);
        end
        out_ready = 1'b1;
        nextCycle();
        checkOutput("s3_xfer_count", xfer_val.size(), 64);
        checkOutput("s3_issue_count", iss_addr.size(), 64);
        if (xfer_val.size() >= 64) begin
            checkOutput("s3_first", xfer_val[0], 10);
            checkOutput("s3_top", xfer_val[53], 63);
            checkOutput("s3_wrap", xfer_val[54], 0);
            checkOutput("s3_last", xfer_val[63], 9);
        end

        $display("[TB] scenario: zero length");
        applyStimulus(6'd33, 7'd0, 1'b1);
        checkOutput("s4_done", done, 1);
        checkOutput("s4_busy", busy, 0);
        checkOutput("s4_out_valid", out_valid, 0);
        checkOutput("s4_rdaddr", rdaddr, 10);
        nextCycle();
        checkOutput("s4_done_once", done, 0);

        $display("[TB] scenario: 20-cycle stall with ignored second start");
        out_ready = 1'b0;
        applyStimulus(6'd0, 7'd8, 1'b1);
        repeat (9) nextCycle();
        applyStimulus(6'd40, 7'd5, 1'b0);
        repeat (10) nextCycle();
        checkOutput("s5_stall_valid", out_valid, 1);
        checkOutput("s5_stall_head", out_data, 0);
        checkOutput("s5_stall_rdaddr", rdaddr, 2);
        checkOutput("s5_stall_issues", iss_addr.size(), 2);
        out_ready = 1'b1;
        waitDone(60);
        checkOutput("s5_xfer_count", xfer_val.size(), 8);
        checkOutput("s5_done_count", done_log.size(), 1);
        if (xfer_val.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput("s5_word", xfer_val[i], i);
            end
        end

        $display("[TB] scenario: reset with two words buffered");
        out_ready = 1'b0;
        applyStimulus(6'd0, 7'd8, 1'b1);
        repeat (6) nextCycle();
        checkOutput("s6_pre_valid", out_valid, 1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("s6_out_valid", out_valid, 0);
        checkOutput("s6_busy", busy, 0);
        checkOutput("s6_done", done, 0);
        checkOutput("s6_rdaddr", rdaddr, 0);
        nextCycle();
        scenarioShortRun();
        repeat (3) nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
